// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM pipeline stage moving 32-bit words over a 16-bit SRAM in two half-word phases.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 3,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic [31:0]        alu_res_in,
  input  logic [31:0]        val_Rm_in,
  input  logic [3:0]         dest_in,
  output logic               ready,
  output logic [31:0]        mem_fwd_value,
  output logic               wb_en_hazard,
  output logic [3:0]         dest_hazard,
  output logic               wb_en_out,
  output logic               mem_r_en_out,
  output logic [31:0]        alu_res_out,
  output logic [31:0]        mem_data_out,
  output logic [3:0]         dest_out,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(ACCESS_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         rdata_q;
  logic [SRAM_AW-1:0]  sram_addr_q;
  logic [15:0]         sram_dq_o_q;
  logic                sram_dq_oe_q;
  logic                sram_we_n_q;
  logic                sram_oe_n_q;
  logic                wb_en_q;
  logic                mem_r_en_q;
  logic [31:0]         alu_res_q;
  logic [31:0]         mem_data_q;
  logic [3:0]          dest_q;

  logic                mem_op;
  logic                is_store;
  logic                is_load;
  logic [31:0]         offset;
  logic [SRAM_AW-2:0]  word_idx;
  logic                unused_offset_bits;

  assign mem_op   = mem_r_en_in | mem_w_en_in;
  // Both enables set behaves as a store.
  assign is_store = mem_w_en_in;
  assign is_load  = mem_r_en_in & ~mem_w_en_in;

  // Out-of-range addresses simply wrap into the SRAM word space.
  assign offset             = alu_res_in - 32'(BASE_ADDR);
  assign word_idx           = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign ready         = ~mem_op | (state_q == DONE);
  assign mem_fwd_value = alu_res_in;
  assign wb_en_hazard  = wb_en_in;
  assign dest_hazard   = dest_in;

  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_o    = sram_dq_o_q;
  assign sram_dq_oe   = sram_dq_oe_q;
  assign sram_we_n    = sram_we_n_q;
  assign sram_oe_n    = sram_oe_n_q;

  // SRAM strobes are registered: they are set up on the edge entering each cycle of a phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_dq_o_q  <= '0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q      <= LO;
            cnt_q        <= '0;
            sram_addr_q  <= {word_idx, 1'b0};
            sram_dq_o_q  <= val_Rm_in[15:0];
            sram_dq_oe_q <= is_store;
            sram_we_n_q  <= ~is_store;
            sram_oe_n_q  <= is_store;
          end
        end
        LO, HI: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (state_q == LO) begin
              if (is_load) rdata_q[15:0] <= sram_dq_i;
              state_q     <= HI;
              sram_addr_q <= {word_idx, 1'b1};
              sram_dq_o_q <= val_Rm_in[31:16];
              sram_we_n_q <= ~is_store;
            end else begin
              if (is_load) rdata_q[31:16] <= sram_dq_i;
              state_q      <= DONE;
              sram_dq_oe_q <= 1'b0;
              sram_we_n_q  <= 1'b1;
              sram_oe_n_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // Release the write strobe one cycle early so data is held past we_n rising.
            if (cnt_q == CNT_PRELAST) sram_we_n_q <= 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (ready) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      alu_res_q  <= alu_res_in;
      dest_q     <= dest_in;
      if (is_load) mem_data_q <= rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - directed self-checking bench for mem_stage_sram_ctrl.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en, r_en, w_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;
  logic        ready, wb_en_hazard, wb_en_out, mem_r_en_out;
  logic [31:0] mem_fwd_value, alu_res_out, mem_data_out;
  logic [3:0]  dest_hazard, dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        r5;
  logic [31:0] a5;
  logic        ready5, wbh5, wbo5, mro5, oe5_en, we5_n, oe5_n;
  logic [31:0] fwd5, aro5, mdo5, dq5_unused;
  logic [3:0]  dh5, do5;
  logic [17:0] addr5;
  logic [15:0] dq5_o, dq5_i;

  logic [15:0] sram_mem [0:262143];

  int errors = 0;
  int checks = 0;

  int          lowcnt, act, cyc_lo, cyc_hi, we_lo, we_hi;
  logic [17:0] addr_lo, addr_hi;
  logic [15:0] dq_lo, dq_hi;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en), .mem_r_en_in(r_en), .mem_w_en_in(w_en),
    .alu_res_in(alu_res), .val_Rm_in(val_rm), .dest_in(dest), .ready(ready),
    .mem_fwd_value(mem_fwd_value), .wb_en_hazard(wb_en_hazard), .dest_hazard(dest_hazard),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .wb_en_in(1'b1), .mem_r_en_in(r5), .mem_w_en_in(1'b0),
    .alu_res_in(a5), .val_Rm_in(32'h0), .dest_in(4'h7), .ready(ready5),
    .mem_fwd_value(fwd5), .wb_en_hazard(wbh5), .dest_hazard(dh5),
    .wb_en_out(wbo5), .mem_r_en_out(mro5), .alu_res_out(aro5),
    .mem_data_out(mdo5), .dest_out(do5), .sram_addr(addr5),
    .sram_dq_o(dq5_o), .sram_dq_oe(oe5_en), .sram_dq_i(dq5_i),
    .sram_we_n(we5_n), .sram_oe_n(oe5_n)
  );

  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];
  assign dq5_i     = oe5_n ? 16'h0000 : (addr5[0] ? 16'h1234 : 16'h5678);

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_op(input logic r, input logic w, input logic wb, input logic [31:0] a,
                        input logic [31:0] v, input logic [3:0] d);
    r_en = r; w_en = w; wb_en = wb; alu_res = a; val_rm = v; dest = d;
    lowcnt = 0; act = 0; cyc_lo = 0; cyc_hi = 0; we_lo = 0; we_hi = 0;
    addr_lo = '0; addr_hi = '0; dq_lo = '0; dq_hi = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lowcnt++;
      if (!sram_oe_n || sram_dq_oe) begin
        if (act == 0) addr_lo = sram_addr;
        act++;
        if (sram_addr == addr_lo) begin
          cyc_lo++;
          if (!sram_we_n) begin we_lo++; dq_lo = sram_dq_o; end
        end else begin
          cyc_hi++;
          addr_hi = sram_addr;
          if (!sram_we_n) begin we_hi++; dq_hi = sram_dq_o; end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic nop;
    r_en = 0; w_en = 0; wb_en = 0; alu_res = 0; val_rm = 0; dest = 0;
  endtask

  initial begin
    nop();
    r5 = 0; a5 = 0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_outs", {wb_en_out, mem_r_en_out, alu_res_out, dest_out}, 0);
    @(negedge clk); rst = 1;

    // ALU op passes straight through in one cycle.
    @(posedge clk); #1;
    wb_en = 1; alu_res = 32'h55; dest = 3;
    @(negedge clk);
    check("add_ready", ready, 1);
    check("add_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
    check("add_fwd", mem_fwd_value, 32'h55);
    check("add_hz", {wb_en_hazard, dest_hazard}, 5'h13);
    @(posedge clk); #1;
    check("add_alu_out", alu_res_out, 32'h55);
    check("add_dest_out", dest_out, 3);
    check("add_wb_out", wb_en_out, 1);

    mem_op(0, 1, 0, 1028, 32'hDEADBEEF, 4'd0);
    check("str_low", lowcnt, 7);
    check("str_addr", {14'h0, addr_lo, 14'h0, addr_hi}, {14'h0, 18'd2, 14'h0, 18'd3});
    check("str_cyc", {cyc_lo[15:0], cyc_hi[15:0]}, {16'd3, 16'd3});
    check("str_we", {we_lo[15:0], we_hi[15:0]}, {16'd2, 16'd2});
    check("str_dq", {dq_hi, dq_lo}, 32'hDEADBEEF);
    check("str_out", {mem_r_en_out, wb_en_out}, 2'b00);
    check("str_alu_out", alu_res_out, 1028);
    check("str_mdata", mem_data_out, 0);

    mem_op(1, 0, 1, 1028, 32'h0, 4'd5);
    check("ldr_low", lowcnt, 7);
    check("ldr_oe_cyc", {cyc_lo[15:0], cyc_hi[15:0]}, {16'd3, 16'd3});
    check("ldr_we", we_lo + we_hi, 0);
    check("ldr_data", mem_data_out, 32'hDEADBEEF);
    check("ldr_r_out", mem_r_en_out, 1);
    check("ldr_dest", dest_out, 5);

    mem_op(0, 1, 0, 1040, 32'h12345678, 4'd0);
    check("str2_low", lowcnt, 7);
    // Both enables set: the store wins, mem_data_out holds.
    mem_op(1, 1, 1, 1048, 32'hCAFEF00D, 4'd2);
    check("both_low", lowcnt, 7);
    check("both_we", {we_lo[15:0], we_hi[15:0]}, {16'd2, 16'd2});
    check("both_r_out", mem_r_en_out, 1);
    check("both_mdata", mem_data_out, 32'hDEADBEEF);
    mem_op(1, 0, 1, 1048, 32'h0, 4'd2);
    check("both_ld", mem_data_out, 32'hCAFEF00D);

    // Reset during the HI phase of a load.
    r_en = 1; w_en = 0; wb_en = 1; alu_res = 1040; dest = 9;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mid_oe_active", sram_oe_n, 0);
    rst = 0; #1;
    check("mid_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
    check("mid_addr", sram_addr, 0);
    check("mid_outs", {alu_res_out, mem_data_out}, 64'h0);
    check("mid_ready", ready, 0);
    nop();
    @(posedge clk); #1; rst = 1;
    mem_op(1, 0, 1, 1040, 32'h0, 4'd9);
    check("restart_low", lowcnt, 7);
    check("restart_data", mem_data_out, 32'h12345678);

    // Address below BASE_ADDR wraps.
    mem_op(0, 1, 0, 0, 32'h00020001, 4'd0);
    check("wrap_addr_lo", addr_lo, 18'h3FE00);
    check("wrap_addr_hi", addr_hi, 18'h3FE01);
    mem_op(1, 0, 1, 0, 32'h0, 4'd1);
    check("wrap_data", mem_data_out, 32'h00020001);
    nop();

    // ACCESS_CYCLES=5 instance.
    r5 = 1; a5 = 1024; lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready5) break;
      lowcnt++;
    end
    @(posedge clk); #1;
    check("ac5_low", lowcnt, 11);
    check("ac5_data", mdo5, 32'h12345678);
    r5 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
